// File: rtl/irq_ctrl.sv
// irq_ctrl: small interrupt controller with pending/mask registers and a
// three-state request/service handshake toward the CPU.
// Build option: define IRQ_LEVEL_EN for level-sensitive pending bits
// (PEND follows irq_in registered; W1C and ack-clear have no effect).
// Default build latches rising edges of irq_in into PEND.
module irq_ctrl #(
  parameter int unsigned N_IRQ = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [31:0]       din,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              int_ack,
  input  logic              eret,
  output logic              int_req,
  output logic [2:0]        int_id,
  output logic [31:0]       dout
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, state_nx;
  logic [2:0]       id_nx;
  logic [2:0]       low_id;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] active;
  logic [7:0]       active8;
  logic             unused_din_hi;

  assign active        = pend & mask;
  assign active8       = 8'(active);
  assign unused_din_hi = ^din[31:N_IRQ];

  // Lowest set index of the enabled pending bits (descending scan, last hit wins)
  always_comb begin
    low_id = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (active[i-1]) low_id = 3'(i - 1);
    end
  end

`ifdef IRQ_LEVEL_EN
  // Level mode: pending bits are a registered copy of the interrupt lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= irq_in;
  end
`else
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;

  assign w1c = (we && addr == 2'd0) ? din[N_IRQ-1:0] : '0;

  // One-hot clear of the presented line when the CPU accepts it
  always_comb begin
    ack_clr = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      ack_clr[i] = (state == REQ) && int_ack && (int_id == 3'(i));
    end
  end

  // Edge mode: clears applied first so a same-cycle rising edge wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev <= '0;
      pend     <= '0;
    end else begin
      irq_prev <= irq_in;
      pend     <= (pend & ~(w1c | ack_clr)) | (irq_in & ~irq_prev);
    end
  end
`endif

  // Mask register write; din bits above the line count are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         mask <= '0;
    else if (we && addr == 2'd1)      mask <= din[N_IRQ-1:0];
  end

  // FSM state and presented-id registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      int_id <= '0;
    end else begin
      state  <= state_nx;
      int_id <= id_nx;
    end
  end

  // Next-state logic; int_id only changes when entering REQ
  always_comb begin
    state_nx = state;
    id_nx    = int_id;
    case (state)
      IDLE: begin
        if (|active) begin
          state_nx = REQ;
          id_nx    = low_id;
        end
      end
      REQ: begin
        if (int_ack)                state_nx = SERVICE;
        else if (!active8[int_id])  state_nx = IDLE;
      end
      SERVICE: begin
        if (eret) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign int_req = (state == REQ);

  // Register read mux
  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout = 32'(pend);
      2'd1:    dout = 32'(mask);
      2'd2:    dout = {28'b0, (state == SERVICE), int_id};
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (default edge build).
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [5:0]  irq_in;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  logic [2:0]  int_id;
  logic [31:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl #(.N_IRQ(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .eret    (eret),
    .int_req (int_req),
    .int_id  (int_id),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; din = d;
    tick();
    we = 1'b0; din = '0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; we = 1'b0; addr = '0; din = '0;
    irq_in = '0; int_ack = 1'b0; eret = 1'b0;

    // Reset state
    #3;
    check("rst_req", {31'b0, int_req}, 32'h0);
    rdchk("rst_pend", 2'd0, 32'h0);
    rdchk("rst_stat", 2'd2, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single timer interrupt, full handshake
    wr(2'd1, 32'h1);
    rdchk("mask_rd", 2'd1, 32'h1);
    irq_in = 6'h01;
    tick();
    rdchk("t1_pend", 2'd0, 32'h1);
    check("t1_req_k", {31'b0, int_req}, 32'h0);
    tick();
    check("t1_req", {31'b0, int_req}, 32'h1);
    check("t1_id", {29'b0, int_id}, 32'h0);
    pulse_ack();
    rdchk("t1_stat_svc", 2'd2, 32'h8);
    rdchk("t1_pend_ack", 2'd0, 32'h0);
    check("t1_req_svc", {31'b0, int_req}, 32'h0);
    pulse_eret();
    rdchk("t1_stat_idle", 2'd2, 32'h0);
    irq_in = '0;
    tick();

    // Two simultaneous lines, priority, and late higher-priority arrival
    wr(2'd1, 32'h3F);
    irq_in = 6'h24;
    tick();
    rdchk("t2_pend", 2'd0, 32'h24);
    tick();
    check("t2_id2", {29'b0, int_id}, 32'h2);
    pulse_ack();
    rdchk("t2_stat", 2'd2, 32'hA);
    rdchk("t2_pend_ack", 2'd0, 32'h20);
    pulse_eret();
    tick();
    check("t2_req5", {31'b0, int_req}, 32'h1);
    check("t2_id5", {29'b0, int_id}, 32'h5);
    irq_in = 6'h25;
    tick();
    check("t2_id_hold", {29'b0, int_id}, 32'h5);
    rdchk("t2_pend_late", 2'd0, 32'h21);
    pulse_ack();
    rdchk("t2_stat5", 2'd2, 32'hD);
    rdchk("t2_pend_ack5", 2'd0, 32'h01);
    pulse_eret();
    tick();
    check("t2_id0", {29'b0, int_id}, 32'h0);
    pulse_ack();
    pulse_eret();
    irq_in = '0;
    tick();
    rdchk("t2_pend_end", 2'd0, 32'h0);

    // Masked pending line becomes visible when unmasked
    wr(2'd1, 32'h0);
    irq_in = 6'h08;
    tick();
    rdchk("t3_pend", 2'd0, 32'h08);
    tick(); tick();
    check("t3_req_masked", {31'b0, int_req}, 32'h0);
    wr(2'd1, 32'h08);
    check("t3_req_wr", {31'b0, int_req}, 32'h0);
    tick();
    check("t3_req", {31'b0, int_req}, 32'h1);
    check("t3_id", {29'b0, int_id}, 32'h3);
    pulse_ack();
    pulse_eret();
    irq_in = '0;
    tick();

    // Withdrawal when the presented bit is cleared by software
    wr(2'd1, 32'h02);
    irq_in = 6'h02;
    tick(); tick();
    check("t4_req", {31'b0, int_req}, 32'h1);
    check("t4_id", {29'b0, int_id}, 32'h1);
    wr(2'd0, 32'h2);
    tick();
    check("t4_withdraw", {31'b0, int_req}, 32'h0);
    rdchk("t4_pend", 2'd0, 32'h0);
    addr = 2'd2; #1;
    check("t4_not_svc", {31'b0, dout[3]}, 32'h0);
    tick();
    check("t4_stay_idle", {31'b0, int_req}, 32'h0);
    irq_in = '0;
    tick();

    // Set beats W1C in the same cycle; plain W1C clears
    wr(2'd1, 32'h0);
    irq_in = 6'h01;
    wr(2'd0, 32'h1);
    rdchk("t5_set_wins", 2'd0, 32'h01);
    wr(2'd0, 32'h1);
    rdchk("t5_w1c", 2'd0, 32'h0);

    // Upper din bits ignored, unused register reads zero, ignored writes
    wr(2'd1, 32'hFFFF_FFC0);
    rdchk("t5_mask_hi", 2'd1, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rdchk("t5_mask_all", 2'd1, 32'h3F);
    wr(2'd3, 32'h0);
    rdchk("t5_wr3_ign", 2'd1, 32'h3F);
    rdchk("t5_addr3", 2'd3, 32'h0);

    // Asynchronous reset during SERVICE, then edge detection after release
    irq_in = '0;
    tick();
    irq_in = 6'h10;
    tick(); tick();
    check("t6_id4", {29'b0, int_id}, 32'h4);
    pulse_ack();
    rdchk("t6_stat_svc", 2'd2, 32'hC);
    rst = 1'b0;
    #1;
    check("t6_rst_req", {31'b0, int_req}, 32'h0);
    rdchk("t6_rst_stat", 2'd2, 32'h0);
    rdchk("t6_rst_mask", 2'd1, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rdchk("t6_edge_after", 2'd0, 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 6, number of hardware interrupt lines (legal 1..8); irq_in bit 0 carries the timer IRQ.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 we  input  1  register write enable.
REQ-005 addr  input  2  register select: 0 PEND, 1 MASK, 2 STAT, 3 unused.
REQ-006 din  input  32  write data.
REQ-007 irq_in  input  N_IRQ  device interrupt lines, level, synchronous to clk.
REQ-008 int_ack  input  1  CPU accepts the presented interrupt (one-cycle pulse).
REQ-009 eret  input  1  CPU exits handler (one-cycle pulse).
REQ-010 int_req  output  1  interrupt request to CPU, driven from state register.
REQ-011 int_id  output  3  index of presented or in-service line.
REQ-012 dout  output  32  combinational read data for addr.

Function
REQ-013 FSM states SHALL be IDLE, REQ, SERVICE; int_req SHALL be 1 only in REQ.
REQ-014 irq_prev SHALL register irq_in each cycle; a rising edge (irq_in=1, irq_prev=0) at clock k SHALL set PEND bit at clock k.
REQ-015 IDLE: if (PEND & MASK) != 0 at clock k, SHALL go to REQ and latch int_id = lowest set index of (PEND & MASK) at clock k+1.
REQ-016 REQ: int_id SHALL stay fixed; a later higher-priority arrival SHALL NOT change it.
REQ-017 REQ with int_ack=1: SHALL go to SERVICE and clear PEND[int_id] in the same clock.
REQ-018 REQ with the latched bit no longer in (PEND & MASK) and int_ack=0: SHALL withdraw to IDLE, int_req falls next cycle.
REQ-019 SERVICE: SHALL hold int_id; eret=1 SHALL return to IDLE; int_ack ignored.
REQ-020 Write addr 0: SHALL clear PEND bits where din is 1 (write-1-to-clear).
REQ-021 Write addr 1: MASK <= din[N_IRQ-1:0]; writes to addr 2 and 3 SHALL be ignored.
REQ-022 Same-cycle set (edge) and clear (W1C or ack) on one PEND bit: set SHALL win.
REQ-023 dout: addr 0 {zeros, PEND}; addr 1 {zeros, MASK}; addr 2 {28'b0, in_service, int_id}, in_service = state==SERVICE; addr 3 32'h0.
REQ-024 Bits of din above N_IRQ-1 SHALL be ignored; unused dout bits SHALL read 0.

Reset
REQ-025 rst=0 SHALL immediately force PEND=0, MASK=0, irq_prev=0, state IDLE, int_id=0, int_req=0, regardless of clock or FSM state.
REQ-026 Reset asserted mid-REQ or mid-SERVICE SHALL drop int_req without requiring ack or eret; first edge after release SHALL be detected normally.

Configuration
REQ-027 Macro IRQ_LEVEL_EN defined: PEND SHALL equal irq_in registered each cycle (level-sensitive), W1C and ack-clear SHALL have no effect, irq_prev unused.
REQ-028 IRQ_LEVEL_EN undefined: edge-latched PEND per REQ-014, REQ-017, REQ-020, REQ-022.

Verification
REQ-029 MASK=6'h01, irq_in[0] rises at clock k -> PEND=6'h01 at k, int_req=1 and int_id=0 after k+1; int_ack -> STAT reads 32'h8, PEND=0; eret -> IDLE, STAT 32'h0.
REQ-030 MASK=6'h3F, irq_in 6'h24 rises in one cycle -> int_id=2; after ack and eret, int_id=5 presented next.
REQ-031 MASK=0, irq_in[3] rises -> PEND=6'h08, int_req stays 0; write MASK=6'h08 -> int_req=1, int_id=3 two cycles later.
REQ-032 In REQ for id 1, write PEND din=32'h2 with no ack -> int_req=0 next cycle, state IDLE.
REQ-033 W1C of bit 0 in the same cycle as irq_in[0] rising edge -> PEND[0]=1.
REQ-034 In SERVICE, pull rst low between clocks -> int_req=0, dout at addr 2 reads 32'h0 immediately; with IRQ_LEVEL_EN, held irq_in[4]=1 keeps PEND[4]=1 after W1C.
